// File: rtl/mem_bist_initiator_if.sv
// 16x8 memory bus shared by the BIST engine and the memory target.
// Read data for the address driven in cycle n is returned in cycle n+1.
interface mem_if (
  input logic clk
);
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport initiator (
    input  rdata,
    output we,
    output addr,
    output wdata
  );

  modport target (
    input  clk,
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/mem_bist_initiator.sv
// March-style BIST engine: write/read true pattern, then inverted.
// Reports pass, miscompare count and the first failing location.
module mem_bist_initiator #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  mem_if.initiator        mem,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [5:0]      err_count,
  output logic [3:0]      fail_addr,
  output logic [7:0]      fail_data,
  output logic            fail_phase
);

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    FLUSH
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] exp;
    logic [3:0] addr;
    logic       phase;
  } cmp_t;

  function automatic logic [7:0] pat(input logic [3:0] a);
    return {a, ~a} ^ SEED;
  endfunction

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  cmp_t       cmp_q, cmp_n;
  logic       launch;
  logic       we_n;
  logic [3:0] addr_n;
  logic [7:0] wdata_n;
  logic       miss;
  logic [5:0] err_n;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = WR0;
          cnt_n   = 4'd0;
          launch  = 1'b1;
        end
      end
      WR0: begin
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_n = RD0;
      end
      RD0: begin
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_n = WR1;
      end
      WR1: begin
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_n = RD1;
      end
      RD1: begin
        cnt_n = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_n = FLUSH;
      end
      FLUSH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Bus outputs are computed from next state so they leave a flop.
  always_comb begin
    we_n    = 1'b0;
    addr_n  = 4'd0;
    wdata_n = 8'd0;
    unique case (1'b1)
      (state_n == WR0): begin
        we_n    = 1'b1;
        addr_n  = cnt_n;
        wdata_n = pat(cnt_n);
      end
      (state_n == WR1): begin
        we_n    = 1'b1;
        addr_n  = cnt_n;
        wdata_n = ~pat(cnt_n);
      end
      (state_n == RD0 || state_n == RD1): begin
        addr_n = cnt_n;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    cmp_n.vld   = (state_q == RD0) || (state_q == RD1);
    cmp_n.exp   = (state_q == RD1) ? ~pat(cnt_q) : pat(cnt_q);
    cmp_n.addr  = cnt_q;
    cmp_n.phase = (state_q == RD1);
    miss        = cmp_q.vld && (mem.rdata != cmp_q.exp);
    err_n       = err_count + {5'd0, miss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cmp_q      <= '0;
      mem.we     <= 1'b0;
      mem.addr   <= 4'd0;
      mem.wdata  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 6'd0;
      fail_addr  <= 4'd0;
      fail_data  <= 8'd0;
      fail_phase <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      cmp_q     <= cmp_n;
      mem.we    <= we_n;
      mem.addr  <= addr_n;
      mem.wdata <= wdata_n;
      busy      <= (state_n != IDLE);
      done      <= (state_q == FLUSH);
      if (launch) begin
        err_count  <= 6'd0;
        fail_addr  <= 4'd0;
        fail_data  <= 8'd0;
        fail_phase <= 1'b0;
      end else if (miss) begin
        err_count <= err_n;
        if (err_count == 6'd0) begin
          fail_addr  <= cmp_q.addr;
          fail_data  <= mem.rdata;
          fail_phase <= cmp_q.phase;
        end
      end
      // FLUSH holds the last compare, so err_n is the final count.
      if (state_q == FLUSH) pass <= (err_n == 6'd0);
    end
  end

endmodule
